btn_pulse_conditioner: RTL and testbench

Upstream input stage for the game core. Synchronises, debounces and edge-detects the raw push-buttons (BtnL, BtnU, BtnD, BtnR, BtnC). Produces, per button, a clean debounced level, a single-cycle press pulse (SCEN) and an auto-repeat pulse train while held (MCEN). These outputs drive Start/Ack/Jump into the X pipe engine, obstacle logic and flight physics, replacing the raw button wiring.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_debounce_fsm.sv | 91 +++++++++
 rtl/btn_pulse_conditioner.sv | 37 +++
 tb/tb_btn_pulse_conditioner.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioning path: FSM state encoding,
// 50 MHz board timing defaults and button channel indices.
package btn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_PRESS   = 3'd1,
        ST_PULSE        = 3'd2,
        ST_HELD         = 3'd3,
        ST_WAIT_RELEASE = 3'd4
    } btn_state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;    // 10 ms at 50 MHz
    localparam int unsigned DEFAULT_REPEAT_CYCLES   = 10000000;  // 200 ms at 50 MHz

    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_D = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_C = 4;

endpackage

// File: rtl/btn_debounce_fsm.sv
// Single button channel: 2-flop synchroniser, debounce/hold FSM and shared counter.
// Outputs are decoded purely from state and counter registers.
module btn_debounce_fsm
    import btn_pkg::*;
#(
    parameter int unsigned CNT_W           = 24,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse,
    output logic o_repeat
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            unique case (r_state)
                ST_IDLE: begin
                    if (r_sync2) begin
                        r_state <= ST_WAIT_PRESS;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_PRESS: begin
                    // Any low sample throws away the partial qualification.
                    if (!r_sync2) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= ST_PULSE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_PULSE: begin
                    r_state <= ST_HELD;
                    r_cnt   <= '0;
                end
                ST_HELD: begin
                    if (!r_sync2) begin
                        r_state <= ST_WAIT_RELEASE;
                        r_cnt   <= '0;
                    end else if (r_cnt == REP_LAST) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    // A re-close during release is bounce: back to held, no new press.
                    if (r_sync2) begin
                        r_state <= ST_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level  = (r_state == ST_PULSE) || (r_state == ST_HELD) ||
                      (r_state == ST_WAIT_RELEASE);
    assign o_pulse  = (r_state == ST_PULSE);
    assign o_repeat = (r_state == ST_PULSE) || ((r_state == ST_HELD) && (r_cnt == REP_LAST));

endmodule

// File: rtl/btn_pulse_conditioner.sv
// Push-button front end: one independent debounce channel per button plus a
// combined press strobe for consumers that do not care which button fired.
module btn_pulse_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTNS          = 5,
    parameter int unsigned CNT_W           = 24,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [N_BTNS-1:0] Btn_In,
    output logic [N_BTNS-1:0] Btn_Level,
    output logic [N_BTNS-1:0] Btn_Pulse,
    output logic [N_BTNS-1:0] Btn_Repeat,
    output logic              Any_Pulse
);

    for (genvar g = 0; g < N_BTNS; g++) begin : g_chan
        btn_debounce_fsm #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_fsm (
            .i_clk    (Clk),
            .i_rst    (reset),
            .i_btn    (Btn_In[g]),
            .o_level  (Btn_Level[g]),
            .o_pulse  (Btn_Pulse[g]),
            .o_repeat (Btn_Repeat[g])
        );
    end

    assign Any_Pulse = |Btn_Pulse;

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Self-checking bench for btn_pulse_conditioner with short debounce/repeat timing:
// segment table, hand-written reset sequence and random stimulus against a run-length model.
module tb_btn_pulse_conditioner;

    localparam int NB = 5;
    localparam int D  = 4;
    localparam int R  = 8;

    logic          Clk;
    logic          reset;
    logic [NB-1:0] Btn_In;
    logic [NB-1:0] Btn_Level;
    logic [NB-1:0] Btn_Pulse;
    logic [NB-1:0] Btn_Repeat;
    logic          Any_Pulse;

    btn_pulse_conditioner #(
        .N_BTNS          (NB),
        .CNT_W           (24),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R)
    ) dut (
        .Clk        (Clk),
        .reset      (reset),
        .Btn_In     (Btn_In),
        .Btn_Level  (Btn_Level),
        .Btn_Pulse  (Btn_Pulse),
        .Btn_Repeat (Btn_Repeat),
        .Any_Pulse  (Any_Pulse)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a press is accepted after D+1 consecutive high synchronised
    // samples, a release after D+1 consecutive low ones; repeats every R held cycles.
    bit m_d1[NB], m_d2[NB], m_acc[NB], m_pend[NB];
    int m_run[NB], m_age[NB];

    task automatic model_reset();
        for (int c = 0; c < NB; c++) begin
            m_d1[c] = 0; m_d2[c] = 0; m_acc[c] = 0; m_pend[c] = 0;
            m_run[c] = 0; m_age[c] = 0;
        end
    endtask

    task automatic model_edge(input logic [NB-1:0] v);
        for (int c = 0; c < NB; c++) begin
            bit s;
            s = m_d2[c];
            if (m_pend[c]) begin
                m_pend[c] = 0; m_age[c] = 0; m_run[c] = 0;
            end else if (!m_acc[c]) begin
                m_run[c] = s ? m_run[c] + 1 : 0;
                if (m_run[c] == D + 1) begin
                    m_acc[c] = 1; m_pend[c] = 1; m_run[c] = 0;
                end
            end else if (s) begin
                m_age[c] = (m_run[c] > 0) ? 0 : (m_age[c] + 1) % R;
                m_run[c] = 0;
            end else begin
                m_run[c]++;
                if (m_run[c] == D + 1) begin
                    m_acc[c] = 0; m_run[c] = 0;
                end
            end
            m_d2[c] = m_d1[c];
            m_d1[c] = v[c];
        end
    endtask

    function automatic logic [15:0] model_out();
        logic [NB-1:0] lv, pu, rp;
        for (int c = 0; c < NB; c++) begin
            lv[c] = m_acc[c];
            pu[c] = m_pend[c];
            rp[c] = m_pend[c] || (m_acc[c] && m_run[c] == 0 && m_age[c] == R - 1);
        end
        return {lv, pu, rp, |pu};
    endfunction

    logic [NB-1:0] seg_pulse;
    int            seg_any;
    int            seg_rep;

    task automatic step(input logic [NB-1:0] v);
        Btn_In = v;
        @(posedge Clk);
        model_edge(v);
        #1;
        chk("model", {Btn_Level, Btn_Pulse, Btn_Repeat, Any_Pulse}, model_out());
        seg_pulse |= Btn_Pulse;
        seg_any   += int'(Any_Pulse);
        seg_rep   += $countones(Btn_Repeat);
    endtask

    typedef struct {
        logic [NB-1:0] btn;
        int            cycles;
        logic [NB-1:0] pulse_or;
        int            any_cnt;
        int            rep_cnt;
        logic [NB-1:0] level_end;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{5'b10000,   40, 5'b10000, 1,   5, 5'b10000};
        vecs[1]  = '{5'b00000,   20, 5'b00000, 0,   0, 5'b00000};
        vecs[2]  = '{5'b00001,    3, 5'b00000, 0,   0, 5'b00000};
        vecs[3]  = '{5'b00000,    1, 5'b00000, 0,   0, 5'b00000};
        vecs[4]  = '{5'b00001,    3, 5'b00000, 0,   0, 5'b00000};
        vecs[5]  = '{5'b00000,   10, 5'b00000, 0,   0, 5'b00000};
        vecs[6]  = '{5'b01010,   12, 5'b01010, 1,   2, 5'b01010};
        vecs[7]  = '{5'b00000,   12, 5'b00000, 0,   0, 5'b00000};
        vecs[8]  = '{5'b00100,   20, 5'b00100, 1,   2, 5'b00100};
        vecs[9]  = '{5'b00000,    3, 5'b00000, 0,   0, 5'b00100};
        vecs[10] = '{5'b00100,    2, 5'b00000, 0,   0, 5'b00100};
        vecs[11] = '{5'b00000,   12, 5'b00000, 0,   0, 5'b00000};
        vecs[12] = '{5'b00100, 1000, 5'b00100, 1, 125, 5'b00100};
        vecs[13] = '{5'b00000,   12, 5'b00000, 0,   0, 5'b00000};

        reset  = 1'b1;
        Btn_In = '0;
        model_reset();
        #1;
        chk("reset_outputs", {Btn_Level, Btn_Pulse, Btn_Repeat, Any_Pulse}, 16'h0);
        @(posedge Clk);
        #2;
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            seg_pulse = '0; seg_any = 0; seg_rep = 0;
            for (int k = 0; k < vecs[i].cycles; k++) step(vecs[i].btn);
            chk($sformatf("seg%0d_pulse", i), seg_pulse, vecs[i].pulse_or);
            chk($sformatf("seg%0d_any_cnt", i), seg_any, vecs[i].any_cnt);
            chk($sformatf("seg%0d_rep_cnt", i), seg_rep, vecs[i].rep_cnt);
            chk($sformatf("seg%0d_level", i), Btn_Level, vecs[i].level_end);
        end

        // Async reset while bit 0 is held, then a fresh qualification with the button still down.
        for (int k = 0; k < 12; k++) step(5'b00001);
        chk("pre_reset_level", Btn_Level, 5'b00001);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {Btn_Level, Btn_Pulse, Btn_Repeat, Any_Pulse}, 16'h0);
        @(posedge Clk);
        #2;
        reset = 1'b0;
        model_reset();
        begin
            int first, cnt;
            first = -1; cnt = 0;
            for (int k = 1; k <= 30; k++) begin
                step(5'b00001);
                if (Btn_Pulse[0]) begin
                    cnt++;
                    if (first < 0) first = k;
                end
            end
            chk("post_reset_pulse_edge", first, 7);
            chk("post_reset_pulse_count", cnt, 1);
        end
        for (int k = 0; k < 12; k++) step(5'b00000);
        chk("post_reset_release", Btn_Level, 5'b00000);

        // Random toggling with runs around the debounce threshold.
        begin
            logic [NB-1:0] cur;
            cur = '0;
            for (int k = 0; k < 3000; k++) begin
                for (int c = 0; c < NB; c++)
                    if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
                step(cur);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
